// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one imem read at a time,
// and drives the IF/ID producer outputs with a one-entry skid buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    FULL,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc_reg;
  logic [31:0] pc_n;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_n;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_n;
  logic        valid_n;
  logic [31:0] out_pc_n;
  logic [31:0] out_instr_n;
  logic        consumed;
  logic        free;

  assign consumed  = fetch_valid && !stall;
  assign free      = !fetch_valid || !stall;
  assign imem_req  = rst_n && (state == ISSUE) && !redirect;
  assign imem_addr = pc_reg;

  always_comb begin
    state_n      = state;
    pc_n         = pc_reg;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    valid_n      = fetch_valid;
    out_pc_n     = fetch_pc;
    out_instr_n  = fetch_instr;
    if (redirect) begin
      pc_n        = {redirect_pc[31:2], 2'b00};
      valid_n     = 1'b0;
      out_instr_n = NOP_INSTR;
      // an outstanding read must still be swallowed
      unique case (state)
        ISSUE, FULL: state_n = ISSUE;
        default:     state_n = imem_rvalid ? ISSUE : DRAIN;
      endcase
    end else begin
      if (consumed) begin
        valid_n     = 1'b0;
        out_instr_n = NOP_INSTR;
      end
      unique case (state)
        ISSUE: state_n = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            pc_n = pc_reg + 32'd4;
            if (free) begin
              valid_n     = 1'b1;
              out_pc_n    = pc_reg;
              out_instr_n = imem_rdata;
              state_n     = ISSUE;
            end else begin
              skid_pc_n    = pc_reg;
              skid_instr_n = imem_rdata;
              state_n      = FULL;
            end
          end
        end
        FULL: begin
          if (consumed) begin
            valid_n     = 1'b1;
            out_pc_n    = skid_pc;
            out_instr_n = skid_instr;
            state_n     = ISSUE;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_n = ISSUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc_reg      <= RESET_PC;
      skid_pc     <= 32'd0;
      skid_instr  <= 32'd0;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'd0;
      fetch_instr <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pc_reg      <= pc_n;
      skid_pc     <= skid_pc_n;
      skid_instr  <= skid_instr_n;
      fetch_valid <= valid_n;
      fetch_pc    <= out_pc_n;
      fetch_instr <= out_instr_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model plus a
// latency-programmable instruction memory responder.
module tb_instr_fetch;

  localparam logic [31:0] NOP   = 32'hFC00_0000;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: presented word + skid as a queue
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_last;
  bit          m_out;
  bit          m_disc;

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat = 1;
  bit          inj = 0;

  logic        act_req, act_valid, act_rv;
  logic [31:0] act_addr, act_pc, act_instr;
  logic [31:0] req_log[$];
  int          req_cyc[$];

  function automatic void model_reset();
    q.delete();
    m_pc     = 32'd0;
    m_last   = 32'd0;
    m_out    = 1'b0;
    m_disc   = 1'b0;
    mem_busy = 1'b0;
  endfunction

  function automatic bit in_issue();
    return !m_out && (q.size() < 2);
  endfunction

  task automatic step(input bit s, input bit r, input logic [31:0] t);
    logic        exp_req;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    bit          hit;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    hit         = mem_busy && (mem_cnt == 1);
    imem_rvalid = inj || hit;
    imem_rdata  = hit ? (mem_addr ^ XMASK) : 32'($urandom());
    #4;
    exp_req   = rst_n && in_issue() && !r;
    exp_valid = q.size() > 0;
    exp_pc    = exp_valid ? q[0].pc : m_last;
    exp_instr = exp_valid ? q[0].instr : NOP;
    act_req   = imem_req;
    act_addr  = imem_addr;
    act_valid = fetch_valid;
    act_pc    = fetch_pc;
    act_instr = fetch_instr;
    act_rv    = imem_rvalid;
    checks++;
    if (act_req !== exp_req) begin
      failures++;
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, act_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (act_addr !== m_pc) begin
        failures++;
        $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, act_addr, m_pc);
      end
    end
    checks++;
    if (act_valid !== exp_valid) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, act_valid, exp_valid);
    end
    checks++;
    if (act_pc !== exp_pc) begin
      failures++;
      $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
    end
    checks++;
    if (act_instr !== exp_instr) begin
      failures++;
      $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, act_instr, exp_instr);
    end
    if (act_req === 1'b1) begin
      req_log.push_back(act_addr);
      req_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      model_reset();
    end else if (r) begin
      q.delete();
      m_pc = {t[31:2], 2'b00};
      if (m_out) begin
        if (act_rv) begin
          m_out  = 1'b0;
          m_disc = 1'b0;
        end else begin
          m_disc = 1'b1;
        end
      end
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (m_out && act_rv) begin
        m_out = 1'b0;
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          q.push_back('{pc: m_pc, instr: imem_rdata});
          m_pc = m_pc + 32'd4;
        end
      end else if (exp_req) begin
        m_out = 1'b1;
      end
    end
    if (q.size() > 0) m_last = q[0].pc;
    if (!rst_n) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt == 1) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (act_req === 1'b1) begin
        mem_busy = 1'b1;
        mem_cnt  = (lat > 0) ? lat : int'($urandom_range(1, 4));
        mem_addr = act_addr;
      end
    end
    inj = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step(0, 0, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic goto_issue();
    int n = 0;
    while (!in_issue() && n < 20) begin
      step(0, 0, 32'd0);
      n++;
    end
    checks++;
    if (!in_issue()) begin
      failures++;
      $display("FAIL goto_issue timeout got=busy exp=issue");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 32'd0);
    checks++;
    if (act_req !== 1'b0 || act_valid !== 1'b0 ||
        act_instr !== NOP || act_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_out got=%b/%b/%h/%h exp=0/0/%h/0",
               act_req, act_valid, act_instr, act_pc, NOP);
    end
    rst_n = 1'b1;
    step(0, 0, 32'd0);
    checks++;
    if (act_req !== 1'b1 || act_addr !== 32'd0) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/0", act_req, act_addr);
    end
  endtask

  task automatic test_stream();
    int nv = 0;
    int dbl = 0;
    bit prev = 0;
    lat = 1;
    do_reset();
    req_log.delete();
    req_cyc.delete();
    repeat (12) begin
      step(0, 0, 32'd0);
      if (act_valid === 1'b1) begin
        nv++;
        if (prev) dbl++;
        checks++;
        if (act_instr !== (act_pc ^ XMASK)) begin
          failures++;
          $display("FAIL stream_word got=%h exp=%h", act_instr, act_pc ^ XMASK);
        end
      end
      prev = (act_valid === 1'b1);
    end
    checks++;
    if (nv != 5 || dbl != 0) begin
      failures++;
      $display("FAIL stream_rate got=%0d/%0d exp=5/0", nv, dbl);
    end
    checks++;
    if (req_log.size() < 3 || req_log[0] !== 32'd0 ||
        req_log[1] !== 32'd4 || req_log[2] !== 32'd8) begin
      failures++;
      $display("FAIL stream_addrs got=%0d reqs exp=0,4,8", req_log.size());
    end else begin
      checks++;
      if (req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin
        failures++;
        $display("FAIL stream_gap got=%0d,%0d exp=2,2",
                 req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]);
      end
    end
  endtask

  task automatic test_stall_skid();
    int n = 0;
    int nreq = 0;
    lat = 1;
    do_reset();
    while (!(q.size() > 0 && q[0].pc == 32'd8) && n < 20) begin
      step(0, 0, 32'd0);
      n++;
    end
    step(1, 0, 32'd0);
    checks++;
    if (act_req !== 1'b1 || act_addr !== 32'd12 || act_pc !== 32'd8) begin
      failures++;
      $display("FAIL stall_req12 got=%b/%h/%h exp=1/c/8", act_req, act_addr, act_pc);
    end
    repeat (4) begin
      step(1, 0, 32'd0);
      if (act_req === 1'b1) nreq++;
      checks++;
      if (act_valid !== 1'b1 || act_pc !== 32'd8) begin
        failures++;
        $display("FAIL stall_hold got=%b/%h exp=1/8", act_valid, act_pc);
      end
    end
    checks++;
    if (nreq != 0) begin
      failures++;
      $display("FAIL stall_noreq got=%0d exp=0", nreq);
    end
    step(0, 0, 32'd0);
    step(0, 0, 32'd0);
    checks++;
    if (act_valid !== 1'b1 || act_pc !== 32'd12 ||
        act_instr !== (32'd12 ^ XMASK) || act_req !== 1'b1 ||
        act_addr !== 32'd16) begin
      failures++;
      $display("FAIL skid_out got=%b/%h/%h/%b/%h exp=1/c/%h/1/10",
               act_valid, act_pc, act_instr, act_req, act_addr, 32'd12 ^ XMASK);
    end
  endtask

  task automatic test_redirect_issue();
    lat = 1;
    goto_issue();
    step(0, 1, 32'h0000_0103);
    checks++;
    if (act_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_issue_req got=%b exp=0", act_req);
    end
    step(0, 0, 32'd0);
    checks++;
    if (act_req !== 1'b1 || act_addr !== 32'h100 ||
        act_valid !== 1'b0 || act_instr !== NOP) begin
      failures++;
      $display("FAIL redir_issue_tgt got=%b/%h/%b/%h exp=1/100/0/%h",
               act_req, act_addr, act_valid, act_instr, NOP);
    end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    bit seen = 0;
    lat = 4;
    goto_issue();
    step(0, 0, 32'd0);
    step(0, 1, 32'h0000_0200);
    while (!seen && n < 10) begin
      step(0, 0, 32'd0);
      n++;
      seen = (act_rv === 1'b1);
      checks++;
      if (act_valid !== 1'b0 || act_instr !== NOP || act_req !== 1'b0) begin
        failures++;
        $display("FAIL drain got=%b/%h/%b exp=0/%h/0",
                 act_valid, act_instr, act_req, NOP);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stale_rvalid timeout got=none exp=rvalid");
    end
    step(0, 0, 32'd0);
    checks++;
    if (act_req !== 1'b1 || act_addr !== 32'h200 || act_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_wait_tgt got=%b/%h/%b exp=1/200/0",
               act_req, act_addr, act_valid);
    end
  endtask

  task automatic test_redirect_full();
    int n = 0;
    lat = 1;
    while (!(in_issue() && q.size() == 1) && n < 20) begin
      step(0, 0, 32'd0);
      n++;
    end
    step(1, 0, 32'd0);
    step(1, 1, 32'h0000_0300);
    checks++;
    if (act_rv !== 1'b1 || act_valid !== 1'b1) begin
      failures++;
      $display("FAIL redir_rv_setup got=%b/%b exp=1/1", act_rv, act_valid);
    end
    step(0, 0, 32'd0);
    checks++;
    if (act_valid !== 1'b0 || act_instr !== NOP ||
        act_req !== 1'b1 || act_addr !== 32'h300) begin
      failures++;
      $display("FAIL redir_rv_flush got=%b/%h/%b/%h exp=0/%h/1/300",
               act_valid, act_instr, act_req, act_addr, NOP);
    end
    n = 0;
    while (!(in_issue() && q.size() == 1) && n < 20) begin
      step(0, 0, 32'd0);
      n++;
    end
    step(1, 0, 32'd0);
    step(1, 0, 32'd0);
    step(1, 1, 32'h0000_0340);
    checks++;
    if (act_req !== 1'b0 || act_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_setup got=%b/%b exp=0/1", act_req, act_valid);
    end
    step(1, 0, 32'd0);
    checks++;
    if (act_req !== 1'b1 || act_addr !== 32'h340 || act_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_flush got=%b/%h/%b exp=1/340/0",
               act_req, act_addr, act_valid);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    lat = 1;
    goto_issue();
    step(0, 1, 32'hFFFF_FFFC);
    req_log.delete();
    while (req_log.size() < 2 && n < 20) begin
      step(0, 0, 32'd0);
      n++;
    end
    checks++;
    if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC ||
        req_log[1] !== 32'd0) begin
      failures++;
      $display("FAIL wrap got=%0d reqs exp=fffffffc,0", req_log.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    lat = 4;
    while (!(in_issue() && q.size() == 1 && q[0].pc != 32'd0) && n < 30) begin
      step(0, 0, 32'd0);
      n++;
    end
    step(1, 0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 ||
        fetch_instr !== NOP || fetch_pc !== 32'd0) begin
      failures++;
      $display("FAIL async_rst got=%b/%b/%h/%h exp=0/0/%h/0",
               imem_req, fetch_valid, fetch_instr, fetch_pc, NOP);
    end
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    step(0, 0, 32'd0);
    rst_n = 1'b1;
    inj = 1'b1;
    step(0, 0, 32'd0);
    checks++;
    if (act_rv !== 1'b1 || act_req !== 1'b1 || act_addr !== 32'd0) begin
      failures++;
      $display("FAIL late_rv got=%b/%b/%h exp=1/1/0", act_rv, act_req, act_addr);
    end
    n = 0;
    act_valid = 1'b0;
    while (act_valid !== 1'b1 && n < 10) begin
      step(0, 0, 32'd0);
      n++;
    end
    checks++;
    if (act_valid !== 1'b1 || act_pc !== 32'd0 || act_instr !== XMASK) begin
      failures++;
      $display("FAIL post_rst_fetch got=%b/%h/%h exp=1/0/%h",
               act_valid, act_pc, act_instr, XMASK);
    end
  endtask

  task automatic test_random();
    bit          s;
    bit          r;
    logic [31:0] t;
    lat = 0;
    repeat (600) begin
      s = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 8);
      t = 32'($urandom());
      step(s, r, t);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_issue();
    test_redirect_wait();
    test_redirect_full();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
